lcd_hd44780_ctrl: RTL and testbench
===================================

Name: lcd_hd44780_ctrl

Overview:
Parametrised write-only HD44780 character-LCD controller, successor to the fixed 16x2 8-bit board controller. It runs the power-up/init sequence and accepts commands and characters over a valid/ready stream. It generates LCD_EN/LCD_RS/LCD_DATA timing from the clock frequency, supports 8-bit or 4-bit bus mode and 1–4 row geometries, and tracks the cursor. On row overflow it inserts the set-DDRAM-address command itself.

Parameters:
CLK_HZ, 50_000_000, input clock frequency; all delays derive from it.
COLS, 16, characters per row (8..40).
ROWS, 2, display rows (1..4).
BUS_4BIT, 0, 1 = 4-bit interface (data on LCD_DATA[7:4]), 0 = 8-bit.

Ports:
CLOCK_50  in  1  system clock, CLK_HZ.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  request valid.
in_ready  out  1  controller can accept a request.
in_rs  in  1  0 = command byte, 1 = character byte.
in_data  in  8  command or character.
blon  in  1  backlight request.
init_done  out  1  init sequence complete.
cur_row  out  2  tracked cursor row.
cur_col  out  6  tracked cursor column.
LCD_ON  out  1  panel power.
LCD_BLON  out  1  backlight.
LCD_RW  out  1  constant 0 (write only).
LCD_EN  out  1  enable strobe.
LCD_RS  out  1  register select.
LCD_DATA  out  8  LCD data bus.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: LCD_ON=0, LCD_BLON=0, LCD_EN=0, LCD_RS=0, LCD_DATA=0, in_ready=0, init_done=0, cur_row=0, cur_col=0, LCD_RW=0.
- After reset: LCD_ON=1 from the first non-reset cycle. LCD_BLON = blon delayed one cycle.
- Derived cycle counts, each max(1, value):
  - T_PWR = CLK_HZ/50 (20 ms).
  - T_AS = CLK_HZ/10_000_000 (RS/data setup before EN rises).
  - T_EN = CLK_HZ/1_000_000 (EN high, and EN-low gap between nibbles).
  - T_SHORT = CLK_HZ/20_000 (50 µs).
  - T_LONG = CLK_HZ/500 (2 ms).
- FSM states:
  - PWR_WAIT: T_PWR cycles.
  - INIT: walks the ROM sequence.
  - IDLE.
  - SETUP: T_AS cycles; RS/DATA driven, EN=0.
  - EN_HI: T_EN cycles.
  - EN_LO: T_EN cycles; 4-bit mode only, between high and low nibble.
  - EXEC: T_SHORT, or T_LONG for byte 0x01/0x02/0x03 with RS=0.
  - EXEC → next INIT step, or IDLE, or ADDR_FIX.
- Init sequence, RS=0, each write followed by an EXEC wait:
  - 8-bit: 0x30, 0x30, 0x30, 0x38 (N=1 if ROWS>1, else 0x30), 0x0C, 0x01, 0x06.
  - 4-bit: single nibbles 0x3, 0x3, 0x3, 0x2; then full bytes 0x28 (0x20 if ROWS=1), 0x0C, 0x01, 0x06.
  - The first three wake-up writes use T_LONG.
  - init_done rises on entry to IDLE after the last step and stays high until reset.
- 4-bit byte transfer: high nibble on [7:4], then low nibble; [3:0] held 0.
- Handshake:
  - in_ready=1 only in IDLE with init_done=1.
  - Transfer occurs when in_valid && in_ready; in_ready drops the following cycle.
  - in_rs/in_data are captured on the transfer cycle; later changes are ignored.
  - in_valid without ready is held off with no loss.
- Cursor tracking:
  - Row base addresses: 0x00, 0x40, COLS, 0x40+COLS.
  - Character write: cur_col+1. If the result equals COLS: cur_col=0, cur_row=(cur_row+1) mod ROWS, and ADDR_FIX issues command 0x80|base(cur_row) before in_ready reasserts.
  - Command 0x01/0x02/0x03: cursor becomes (0,0).
  - Command with bit7 set: decode the address against the row ranges [base, base+COLS) to set row/col. If out of range, (0,0). The command is passed through unchanged.
  - Other commands leave the cursor unchanged.
- Reset mid-operation: next edge forces LCD_EN=0 and all registers to reset values, then restarts from PWR_WAIT. Any partial transfer is discarded.

Test Plan:
- CLK_HZ=1_000_000, 8-bit, 16x2: release reset → LCD_EN stays 0 for 20000 cycles; then seven EN pulses with LCD_DATA 0x30,0x30,0x30,0x38,0x0C,0x01,0x06 and RS=0; then init_done=1, in_ready=1.
- After init, send in_rs=1, 0x41 → in_ready=0 next cycle; RS=1, DATA=0x41 for 1 cycle before a 1-cycle EN pulse; in_ready back after 50 cycles; cur_col=1.
- Write 16 chars from (0,0) → 17th EN pulse is RS=0, DATA=0xC0; cursor (1,0); in_ready returns only after that pulse's EXEC.
- COLS=20, ROWS=4: fill rows 0–3 → auto commands 0xC0, 0x94, 0xD4, then 0x80 wrapping to row 0.
- Command 0x01 at cursor (1,5) → in_ready stays low 2000 EXEC cycles; cursor (0,0). Command 0xC3 → cursor (1,3).
- BUS_4BIT=1: init nibbles 0x3,0x3,0x3,0x2 then 0x28; char 0x5A → LCD_DATA[7:4]=0x5 then 0xA with an EN-low gap; [3:0]=0. Separately, assert reset during EN_HI → LCD_EN=0 next edge and 20 ms wait restarts.

Source files
------------

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character-LCD controller: power-up init, valid/ready byte stream,
// 8/4-bit bus timing and cursor tracking with automatic row wrap.
module lcd_hd44780_ctrl #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int COLS     = 16,
    parameter int ROWS     = 2,
    parameter bit BUS_4BIT = 1'b0
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    input  logic       blon,
    output logic       init_done,
    output logic [1:0] cur_row,
    output logic [5:0] cur_col,
    output logic       LCD_ON,
    output logic       LCD_BLON,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS,
    output logic [7:0] LCD_DATA
);

    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    localparam logic [31:0] T_PWR   = 32'(max1(CLK_HZ / 50));
    localparam logic [31:0] T_AS    = 32'(max1(CLK_HZ / 10_000_000));
    localparam logic [31:0] T_EN    = 32'(max1(CLK_HZ / 1_000_000));
    localparam logic [31:0] T_SHORT = 32'(max1(CLK_HZ / 20_000));
    localparam logic [31:0] T_LONG  = 32'(max1(CLK_HZ / 500));

    localparam logic [2:0] LAST_STEP = BUS_4BIT ? 3'd7 : 3'd6;
    localparam logic [5:0] COLS_W    = 6'(COLS);
    localparam logic [1:0] ROW_MAX   = 2'(ROWS - 1);

    typedef enum logic [2:0] {
        S_PWR, S_INIT, S_IDLE, S_SETUP, S_EN_HI, S_EN_LO, S_EXEC, S_FIX
    } state_t;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        logic [7:0] b;
        if (BUS_4BIT) begin
            case (idx)
                3'd0, 3'd1, 3'd2: b = 8'h30;
                3'd3:             b = 8'h20;
                3'd4:             b = (ROWS > 1) ? 8'h28 : 8'h20;
                3'd5:             b = 8'h0C;
                3'd6:             b = 8'h01;
                default:          b = 8'h06;
            endcase
        end else begin
            case (idx)
                3'd0, 3'd1, 3'd2: b = 8'h30;
                3'd3:             b = (ROWS > 1) ? 8'h38 : 8'h30;
                3'd4:             b = 8'h0C;
                3'd5:             b = 8'h01;
                default:          b = 8'h06;
            endcase
        end
        return b;
    endfunction

    function automatic logic [7:0] row_base(input logic [1:0] r);
        logic [7:0] b;
        case (r)
            2'd0:    b = 8'h00;
            2'd1:    b = 8'h40;
            2'd2:    b = 8'(COLS);
            default: b = 8'h40 + 8'(COLS);
        endcase
        return b;
    endfunction

    // In 4-bit mode the first bus phase carries the high nibble on [7:4].
    function automatic logic [7:0] bus_hi(input logic [7:0] b);
        return BUS_4BIT ? {b[7:4], 4'h0} : b;
    endfunction

    function automatic logic is_long(input logic rs, input logic [7:0] b);
        return !rs && (b == 8'h01 || b == 8'h02 || b == 8'h03);
    endfunction

    state_t      state;
    logic [31:0] cnt;
    logic [2:0]  step;
    logic [3:0]  lo_q;
    logic        low_nib;
    logic        single;
    logic        long_q;
    logic        fix;
    logic [1:0]  dec_row;
    logic [5:0]  dec_col;
    logic [7:0]  addr;
    logic [7:0]  fix_byte;

    assign LCD_RW   = 1'b0;
    assign addr     = {1'b0, in_data[6:0]};
    assign fix_byte = 8'h80 | row_base(cur_row);

    // Lowest matching row wins; no match leaves the defaults at (0,0).
    always_comb begin
        dec_row = '0;
        dec_col = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (addr >= row_base(2'(r)) &&
                addr < row_base(2'(r)) + 8'(COLS)) begin
                dec_row = 2'(r);
                dec_col = 6'(addr - row_base(2'(r)));
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= S_PWR;
            cnt       <= '0;
            step      <= '0;
            lo_q      <= '0;
            low_nib   <= 1'b0;
            single    <= 1'b0;
            long_q    <= 1'b0;
            fix       <= 1'b0;
            in_ready  <= 1'b0;
            init_done <= 1'b0;
            cur_row   <= '0;
            cur_col   <= '0;
            LCD_ON    <= 1'b0;
            LCD_BLON  <= 1'b0;
            LCD_EN    <= 1'b0;
            LCD_RS    <= 1'b0;
            LCD_DATA  <= '0;
        end else begin
            LCD_ON   <= 1'b1;
            LCD_BLON <= blon;
            unique case (state)
                S_PWR: begin
                    if (cnt == T_PWR - 32'd1) begin
                        cnt   <= '0;
                        state <= S_INIT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_INIT: begin
                    lo_q     <= init_byte(step)[3:0];
                    low_nib  <= 1'b0;
                    single   <= BUS_4BIT && (step < 3'd4);
                    long_q   <= (step < 3'd3) || is_long(1'b0, init_byte(step));
                    LCD_RS   <= 1'b0;
                    LCD_DATA <= bus_hi(init_byte(step));
                    cnt      <= '0;
                    state    <= S_SETUP;
                end
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        lo_q     <= in_data[3:0];
                        low_nib  <= 1'b0;
                        single   <= 1'b0;
                        long_q   <= is_long(in_rs, in_data);
                        LCD_RS   <= in_rs;
                        LCD_DATA <= bus_hi(in_data);
                        cnt      <= '0;
                        state    <= S_SETUP;
                        if (in_rs) begin
                            if (cur_col == COLS_W - 6'd1) begin
                                cur_col <= '0;
                                cur_row <= (cur_row == ROW_MAX) ? 2'd0
                                                                : cur_row + 2'd1;
                                fix     <= 1'b1;
                            end else begin
                                cur_col <= cur_col + 6'd1;
                            end
                        end else if (is_long(1'b0, in_data)) begin
                            cur_row <= '0;
                            cur_col <= '0;
                        end else if (in_data[7]) begin
                            cur_row <= dec_row;
                            cur_col <= dec_col;
                        end
                    end
                end
                S_SETUP: begin
                    if (cnt == T_AS - 32'd1) begin
                        cnt    <= '0;
                        LCD_EN <= 1'b1;
                        state  <= S_EN_HI;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_EN_HI: begin
                    if (cnt == T_EN - 32'd1) begin
                        cnt    <= '0;
                        LCD_EN <= 1'b0;
                        if (BUS_4BIT && !single && !low_nib)
                            state <= S_EN_LO;
                        else
                            state <= S_EXEC;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_EN_LO: begin
                    // Low nibble goes out after the gap, then gets its own setup.
                    if (cnt == T_EN - 32'd1) begin
                        cnt      <= '0;
                        low_nib  <= 1'b1;
                        LCD_DATA <= {lo_q, 4'h0};
                        state    <= S_SETUP;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_EXEC: begin
                    if (cnt == (long_q ? T_LONG : T_SHORT) - 32'd1) begin
                        cnt <= '0;
                        if (!init_done && step != LAST_STEP) begin
                            step  <= step + 3'd1;
                            state <= S_INIT;
                        end else if (fix) begin
                            state <= S_FIX;
                        end else begin
                            init_done <= 1'b1;
                            in_ready  <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_FIX: begin
                    fix      <= 1'b0;
                    lo_q     <= fix_byte[3:0];
                    low_nib  <= 1'b0;
                    single   <= 1'b0;
                    long_q   <= 1'b0;
                    LCD_RS   <= 1'b0;
                    LCD_DATA <= bus_hi(fix_byte);
                    cnt      <= '0;
                    state    <= S_SETUP;
                end
                default: state <= S_PWR;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Bench for lcd_hd44780_ctrl: 8-bit 16x2, 8-bit 20x4 and 4-bit 16x2
// instances at CLK_HZ=1 MHz driven by directed vectors.
module tb_lcd_hd44780_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, rst4, blon;
    logic       valid [3];
    logic       rsi   [3];
    logic [7:0] di    [3];
    logic       ready [3];
    logic       done  [3];
    logic       on    [3];
    logic       bl    [3];
    logic       rw    [3];
    logic       en    [3];
    logic       rso   [3];
    logic [1:0] row   [3];
    logic [5:0] col   [3];
    logic [7:0] dat   [3];

    lcd_hd44780_ctrl #(.CLK_HZ(1_000_000), .COLS(16), .ROWS(2), .BUS_4BIT(1'b0)) u8 (
        .CLOCK_50(clk), .reset(rst8), .in_valid(valid[0]), .in_ready(ready[0]),
        .in_rs(rsi[0]), .in_data(di[0]), .blon(blon), .init_done(done[0]),
        .cur_row(row[0]), .cur_col(col[0]), .LCD_ON(on[0]), .LCD_BLON(bl[0]),
        .LCD_RW(rw[0]), .LCD_EN(en[0]), .LCD_RS(rso[0]), .LCD_DATA(dat[0]));

    lcd_hd44780_ctrl #(.CLK_HZ(1_000_000), .COLS(20), .ROWS(4), .BUS_4BIT(1'b0)) u20 (
        .CLOCK_50(clk), .reset(rst8), .in_valid(valid[1]), .in_ready(ready[1]),
        .in_rs(rsi[1]), .in_data(di[1]), .blon(blon), .init_done(done[1]),
        .cur_row(row[1]), .cur_col(col[1]), .LCD_ON(on[1]), .LCD_BLON(bl[1]),
        .LCD_RW(rw[1]), .LCD_EN(en[1]), .LCD_RS(rso[1]), .LCD_DATA(dat[1]));

    lcd_hd44780_ctrl #(.CLK_HZ(1_000_000), .COLS(16), .ROWS(2), .BUS_4BIT(1'b1)) u4 (
        .CLOCK_50(clk), .reset(rst4), .in_valid(valid[2]), .in_ready(ready[2]),
        .in_rs(rsi[2]), .in_data(di[2]), .blon(blon), .init_done(done[2]),
        .cur_row(row[2]), .cur_col(col[2]), .LCD_ON(on[2]), .LCD_BLON(bl[2]),
        .LCD_RW(rw[2]), .LCD_EN(en[2]), .LCD_RS(rso[2]), .LCD_DATA(dat[2]));

    // Every EN rising edge is logged as {RS, DATA} with its cycle stamp.
    logic [8:0] plog [3][0:255];
    int         pt   [3][0:255];
    int         np   [3] = '{0, 0, 0};
    logic       en_q [3] = '{1'b0, 1'b0, 1'b0};
    int         cyc = 0;

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (en[k] === 1'b1 && en_q[k] === 1'b0 && np[k] < 256) begin
                plog[k][np[k]] = {rso[k], dat[k]};
                pt[k][np[k]]   = cyc;
                np[k]++;
            end
            en_q[k] = en[k];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic r, input logic [7:0] d);
        int t;
        t = 0;
        valid[k] = 1'b1;
        rsi[k]   = r;
        di[k]    = d;
        while (!ready[k] && t < 5000) begin
            tick();
            t++;
        end
        chk("handshake_ready", int'(ready[k]), 1);
        @(posedge clk);
        #1;
        valid[k] = 1'b0;
        rsi[k]   = ~r;
        di[k]    = ~d;
    endtask

    task automatic wait_rdy(input int k, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ready[k] && n < 5000);
    endtask

    typedef struct packed {
        logic        rs;
        logic [7:0]  d;
        logic [1:0]  npl;
        logic [8:0]  p0;
        logic [8:0]  p1;
        logic [1:0]  row;
        logic [5:0]  col;
        logic [11:0] wn;
    } vec_t;

    vec_t       tv     [14];
    logic [8:0] init8  [7]  = '{9'h030, 9'h030, 9'h030, 9'h038, 9'h00C, 9'h001, 9'h006};
    logic [8:0] init4  [12] = '{9'h030, 9'h030, 9'h030, 9'h020, 9'h020, 9'h080,
                                9'h000, 9'h0C0, 9'h000, 9'h010, 9'h000, 9'h060};
    logic [7:0] fix20  [4]  = '{8'hC0, 8'h94, 8'hD4, 8'h80};

    initial begin
        int base, n, rel, t;

        tv[0]  = '{1'b0, 8'hC3, 2'd1, 9'h0C3, 9'h000, 2'd1, 6'd3,  12'd53};
        tv[1]  = '{1'b1, 8'h42, 2'd1, 9'h142, 9'h000, 2'd1, 6'd4,  12'd53};
        tv[2]  = '{1'b1, 8'h43, 2'd1, 9'h143, 9'h000, 2'd1, 6'd5,  12'd53};
        tv[3]  = '{1'b0, 8'h01, 2'd1, 9'h001, 9'h000, 2'd0, 6'd0,  12'd2003};
        tv[4]  = '{1'b0, 8'h8F, 2'd1, 9'h08F, 9'h000, 2'd0, 6'd15, 12'd53};
        tv[5]  = '{1'b1, 8'h44, 2'd2, 9'h144, 9'h0C0, 2'd1, 6'd0,  12'd106};
        tv[6]  = '{1'b0, 8'h0C, 2'd1, 9'h00C, 9'h000, 2'd1, 6'd0,  12'd53};
        tv[7]  = '{1'b0, 8'hA0, 2'd1, 9'h0A0, 9'h000, 2'd0, 6'd0,  12'd53};
        tv[8]  = '{1'b0, 8'hCF, 2'd1, 9'h0CF, 9'h000, 2'd1, 6'd15, 12'd53};
        tv[9]  = '{1'b1, 8'h45, 2'd2, 9'h145, 9'h080, 2'd0, 6'd0,  12'd106};
        tv[10] = '{1'b0, 8'hC7, 2'd1, 9'h0C7, 9'h000, 2'd1, 6'd7,  12'd53};
        tv[11] = '{1'b0, 8'hD0, 2'd1, 9'h0D0, 9'h000, 2'd0, 6'd0,  12'd53};
        tv[12] = '{1'b0, 8'hC2, 2'd1, 9'h0C2, 9'h000, 2'd1, 6'd2,  12'd53};
        tv[13] = '{1'b0, 8'h02, 2'd1, 9'h002, 9'h000, 2'd0, 6'd0,  12'd2003};

        rst8 = 1'b1;
        rst4 = 1'b1;
        blon = 1'b0;
        for (int k = 0; k < 3; k++) begin
            valid[k] = 1'b0;
            rsi[k]   = 1'b0;
            di[k]    = 8'h00;
        end
        repeat (3) tick();

        chk("rst_on",   int'(on[0]), 0);
        chk("rst_blon", int'(bl[0]), 0);
        chk("rst_en",   int'(en[0]), 0);
        chk("rst_rs",   int'(rso[0]), 0);
        chk("rst_data", int'(dat[0]), 0);
        chk("rst_rdy",  int'(ready[0]), 0);
        chk("rst_done", int'(done[0]), 0);
        chk("rst_cur",  int'({row[0], col[0]}), 0);
        chk("rst_rw",   int'(rw[0]), 0);

        blon = 1'b1;
        rst8 = 1'b0;
        rst4 = 1'b0;
        rel  = cyc;
        tick();
        chk("on_after_rst", int'(on[0]), 1);
        chk("blon_delay",   int'(bl[0]), 1);
        chk("rdy_pwr",      int'(ready[0]), 0);

        t = 0;
        while (np[0] == 0 && t < 25000) begin
            tick();
            t++;
        end
        chk("pwr_wait", pt[0][0] - rel, 20002);

        t = 0;
        while (!(done[0] && done[1] && done[2]) && t < 40000) begin
            tick();
            t++;
        end
        chk("init_done8",  int'(done[0]), 1);
        chk("init_done20", int'(done[1]), 1);
        chk("init_done4",  int'(done[2]), 1);
        chk("init_rdy8",   int'(ready[0]), 1);
        chk("init_n8",  np[0], 7);
        chk("init_n20", np[1], 7);
        chk("init_n4",  np[2], 12);
        for (int i = 0; i < 7; i++)
            chk($sformatf("init8_%0d", i), int'(plog[0][i]), int'(init8[i]));
        for (int i = 0; i < 12; i++)
            chk($sformatf("init4_%0d", i), int'(plog[2][i]), int'(init4[i]));

        // First character: exact setup / strobe / execute timing.
        base = np[0];
        send(0, 1'b1, 8'h41);
        tick();
        chk("a_rdy_drop", int'(ready[0]), 0);
        chk("a_setup_en", int'(en[0]), 0);
        chk("a_setup_rs", int'(rso[0]), 1);
        chk("a_setup_dt", int'(dat[0]), 'h41);
        tick();
        chk("a_en_hi", int'(en[0]), 1);
        tick();
        chk("a_en_lo", int'(en[0]), 0);
        wait_rdy(0, n);
        chk("a_exec", n, 50);
        chk("a_np",   np[0] - base, 1);
        chk("a_row",  int'(row[0]), 0);
        chk("a_col",  int'(col[0]), 1);

        for (int i = 0; i < 14; i++) begin
            base = np[0];
            send(0, tv[i].rs, tv[i].d);
            wait_rdy(0, n);
            chk($sformatf("v%0d_wait", i), n, int'(tv[i].wn));
            chk($sformatf("v%0d_np", i), np[0] - base, int'(tv[i].npl));
            chk($sformatf("v%0d_p0", i), int'(plog[0][base]), int'(tv[i].p0));
            if (tv[i].npl == 2'd2)
                chk($sformatf("v%0d_p1", i), int'(plog[0][base + 1]), int'(tv[i].p1));
            chk($sformatf("v%0d_row", i), int'(row[0]), int'(tv[i].row));
            chk($sformatf("v%0d_col", i), int'(col[0]), int'(tv[i].col));
        end

        // Sixteen characters from home: the last one triggers the row fix-up.
        send(0, 1'b0, 8'h80);
        wait_rdy(0, n);
        chk("home_col", int'(col[0]), 0);
        for (int i = 0; i < 16; i++) begin
            base = np[0];
            send(0, 1'b1, 8'(8'h61 + i));
            wait_rdy(0, n);
            chk($sformatf("r16_%0d_wait", i), n, (i == 15) ? 106 : 53);
            chk($sformatf("r16_%0d_p0", i), int'(plog[0][base]), 9'h161 + i);
        end
        chk("r16_np",  np[0] - base, 2);
        chk("r16_fix", int'(plog[0][base + 1]), 9'h0C0);
        chk("r16_row", int'(row[0]), 1);
        chk("r16_col", int'(col[0]), 0);

        // 20x4: fill all rows, checking each automatic address command.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 20; c++) begin
                base = np[1];
                send(1, 1'b1, 8'h30 + 8'(c));
                wait_rdy(1, n);
                if (c == 19) begin
                    chk($sformatf("fill_r%0d_np", r), np[1] - base, 2);
                    chk($sformatf("fill_r%0d_fix", r), int'(plog[1][base + 1]),
                        int'({1'b0, fix20[r]}));
                    chk($sformatf("fill_r%0d_row", r), int'(row[1]), (r + 1) % 4);
                end
            end
        end
        chk("fill_col", int'(col[1]), 0);

        // 4-bit character: two nibble strobes with an EN-low gap.
        base = np[2];
        send(2, 1'b1, 8'h5A);
        wait_rdy(2, n);
        chk("n4_wait", n, 56);
        chk("n4_np",   np[2] - base, 2);
        chk("n4_hi",   int'(plog[2][base]), 9'h150);
        chk("n4_lo",   int'(plog[2][base + 1]), 9'h1A0);
        chk("n4_gap",  pt[2][base + 1] - pt[2][base], 3);
        chk("n4_col",  int'(col[2]), 1);

        // Reset while EN is high restarts from the power-up wait.
        send(2, 1'b1, 8'h33);
        t = 0;
        do begin
            tick();
            t++;
        end while (!en[2] && t < 20);
        chk("rst_mid_en_seen", int'(en[2]), 1);
        rst4 = 1'b1;
        tick();
        chk("rst_mid_en",   int'(en[2]), 0);
        chk("rst_mid_rs",   int'(rso[2]), 0);
        chk("rst_mid_data", int'(dat[2]), 0);
        chk("rst_mid_on",   int'(on[2]), 0);
        chk("rst_mid_done", int'(done[2]), 0);
        chk("rst_mid_rdy",  int'(ready[2]), 0);
        chk("rst_mid_col",  int'(col[2]), 0);
        base = np[2];
        rst4 = 1'b0;
        rel  = cyc;
        t = 0;
        while (np[2] == base && t < 25000) begin
            tick();
            t++;
        end
        chk("rst_mid_pwr",   pt[2][base] - rel, 20002);
        chk("rst_mid_first", int'(plog[2][base]), 9'h030);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
